// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: 1-cycle push/drain, combinational youngest-match forwarding; st_ready drops when full.
// Optional STBUF_COALESCE_EN merges a store into the youngest entry when it targets the same word.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [3:0]    st_be,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [3:0]    ld_be,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data,
  output logic          fwd_stall,
  output logic          mem_wr,
  output logic [31:0]   mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wd,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]      ent_word [DEPTH];
  logic [3:0]       ent_be   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic          full, push, merge;
  logic [29:0]   st_word, ld_word;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign st_word  = st_addr[31:2];
  assign ld_word  = ld_addr[31:2];
  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign st_ready = !full;

  // Loads own the shared address port unless the buffer is full.
  assign mem_wr   = !empty && (!ld_valid || full);
  assign mem_addr = mem_wr ? {ent_word[head], 2'b00} : ld_addr;
  assign mem_be   = ent_be[head];
  assign mem_wd   = ent_data[head];

`ifdef STBUF_COALESCE_EN
  logic [AW-1:0] youngest;
  assign youngest = tail - AW'(1);
  // The youngest entry cannot absorb a merge while it is leaving the buffer.
  assign merge = st_valid && !empty && (ent_word[youngest] == st_word)
                 && !(mem_wr && (cnt == CW'(1)));
  assign push  = st_valid && st_ready && !merge;
`else
  assign merge = 1'b0;
  assign push  = st_valid && st_ready;
`endif

  logic          found;
  logic [3:0]    match_be;
  logic [31:0]   match_data;
  logic [AW-1:0] idx;

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    found      = 1'b0;
    match_be   = '0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (ent_vld[idx] && (ent_word[idx] == ld_word)) begin
        found      = 1'b1;
        match_be   = ent_be[idx];
        match_data = ent_data[idx];
      end
    end
  end

  logic covered;
  assign covered   = ((match_be & ld_be) == ld_be);
  assign fwd_stall = ld_valid && (mem_wr || (found && !covered));
  assign fwd_hit   = ld_valid && found && covered && !mem_wr;
  assign fwd_data  = fwd_hit ? (match_data & lane_mask(ld_be)) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (mem_wr) begin
        ent_vld[head] <= 1'b0;
        head          <= head + AW'(1);
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + AW'(1);
      end
      case ({push, mem_wr})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: validity is tracked by ent_vld and cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_word[tail] <= st_word;
      ent_be[tail]   <= st_be;
      ent_data[tail] <= st_data;
    end
`ifdef STBUF_COALESCE_EN
    if (merge) begin
      ent_be[youngest]   <= ent_be[youngest] | st_be;
      ent_data[youngest] <= (ent_data[youngest] & ~lane_mask(st_be))
                            | (st_data & lane_mask(st_be));
    end
`endif
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid, ld_valid;
  logic [31:0]   st_addr, st_data, ld_addr;
  logic [3:0]    st_be, ld_be;
  logic          st_ready, fwd_hit, fwd_stall, mem_wr, empty;
  logic [31:0]   fwd_data, mem_addr, mem_wd;
  logic [3:0]    mem_be;
  logic [CW-1:0] count;

  dm_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_be(st_be), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wd(mem_wd),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] w;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic e_wr;

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for one cycle and compare every output with the model.
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la,
                       input logic [3:0] lbe);
    int   j;
    logic e_full, e_hit, e_stall, cov;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_be = sbe; st_data = sd;
    ld_valid = lv; ld_addr = la; ld_be = lbe;
    #1;
    j = -1;
    foreach (q[i]) if (q[i].w == la[31:2]) j = i;
    e_full  = (q.size() == DEPTH);
    e_wr    = (q.size() != 0) && (!lv || e_full);
    cov     = (j >= 0) && ((q[j].be & lbe) == lbe);
    e_stall = lv && (e_wr || (j >= 0 && !cov));
    e_hit   = lv && cov && !e_wr;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(!e_full));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    if (e_wr) begin
      chk("mem_addr_drain", mem_addr, {q[0].w, 2'b00});
      chk("mem_be", 32'(mem_be), 32'(q[0].be));
      chk("mem_wd", mem_wd, q[0].d);
    end else begin
      chk("mem_addr_load", mem_addr, la);
    end
    chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    chk("fwd_stall", 32'(fwd_stall), 32'(e_stall));
    chk("fwd_data", fwd_data, e_hit ? (q[j].d & lanes(lbe)) : 32'h0);
  endtask

  // Clock edge: retire the drained entry and accept/merge the store in the model.
  task automatic commit();
    logic mrg;
    @(posedge clk);
    mrg = 1'b0;
`ifdef STBUF_COALESCE_EN
    mrg = st_valid && q.size() != 0 && q[$].w == st_addr[31:2] && !(e_wr && q.size() == 1);
    if (mrg) begin
      q[$].be = q[$].be | st_be;
      q[$].d  = (q[$].d & ~lanes(st_be)) | (st_data & lanes(st_be));
    end
`endif
    if (e_wr) void'(q.pop_front());
    if (st_valid && !mrg && (q.size() < DEPTH || e_wr))
      q.push_back('{w: st_addr[31:2], be: st_be, d: st_data});
  endtask

  task automatic cyc(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                     input logic [31:0] sd, input logic lv, input logic [31:0] la,
                     input logic [3:0] lbe);
    drive(sv, sa, sbe, sd, lv, la, lbe);
    commit();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_stall", 32'(fwd_stall), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] ld_be_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  initial begin
    rst_n = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_be = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
    do_reset();

    // Single word store drains when no load competes.
    cyc(1'b1, 32'h10, 4'hF, 32'h11223344, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_mem_wr", 32'(mem_wr), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_wd", mem_wd, 32'h11223344);
    commit();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t1_empty", 32'(empty), 32'd1);
    commit();

    // Full buffer drains even while a load holds the port.
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'h50 + 32'(4 * k), 4'hF, 32'hA000 + 32'(k), 1'b1, 32'h100, 4'hF);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 4'hF);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_st_ready", 32'(st_ready), 32'd0);
    chk("t2_mem_wr", 32'(mem_wr), 32'd1);
    chk("t2_fwd_stall", 32'(fwd_stall), 32'd1);
    commit();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 4'hF);
    chk("t2_count_after", 32'(count), 32'd3);
    commit();
    idle(4);

    // Byte forward hit.
    cyc(1'b1, 32'h20, 4'h2, 32'h0000AB00, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h21, 4'h2);
    chk("t3_hit", 32'(fwd_hit), 32'd1);
    chk("t3_data", fwd_data, 32'h0000AB00);
    chk("t3_stall", 32'(fwd_stall), 32'd0);
    commit();
    idle(2);

    // Partial coverage stalls; after drain the load misses.
    cyc(1'b1, 32'h20, 4'h1, 32'h000000CD, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'hF);
    chk("t4_stall", 32'(fwd_stall), 32'd1);
    chk("t4_hit", 32'(fwd_hit), 32'd0);
    commit();
    idle(1);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'hF);
    chk("t4_nostall", 32'(fwd_stall), 32'd0);
    commit();

    // Youngest of two same-word stores wins; drains keep order.
    cyc(1'b1, 32'h30, 4'hF, 32'hA, 1'b0, 32'h0, 4'h0);
    cyc(1'b1, 32'h30, 4'hF, 32'hB, 1'b1, 32'h30, 4'hF);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h30, 4'hF);
    chk("t5_fwd", fwd_data, 32'hB);
    commit();
`ifndef STBUF_COALESCE_EN
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t5_first", mem_wd, 32'hA);
    commit();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t5_second", mem_wd, 32'hB);
    commit();
`endif
    idle(2);

    // Reset with entries buffered discards them.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'h60 + 32'(4 * k), 4'hF, 32'h600 + 32'(k), 1'b1, 32'h300, 4'hF);
    do_reset();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("t6_no_write", 32'(mem_wr), 32'd0);
    commit();
    idle(2);

`ifdef STBUF_COALESCE_EN
    cyc(1'b1, 32'h40, 4'h1, 32'h00000011, 1'b1, 32'h200, 4'hF);
    cyc(1'b1, 32'h41, 4'h2, 32'h00002200, 1'b1, 32'h200, 4'hF);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h40, 4'h3);
    chk("co_count", 32'(count), 32'd1);
    chk("co_hit", 32'(fwd_hit), 32'd1);
    chk("co_data", fwd_data, 32'h00002211);
    commit();
    idle(2);
`endif

    // Random traffic over a small set of words to provoke hits and stalls.
    for (int n = 0; n < 3000; n++) begin
      logic        sv, lv;
      logic [31:0] sa, la, sd;
      logic [3:0]  sbe;
      if ($urandom_range(0, 599) == 0) do_reset();
      sv  = ($urandom_range(0, 9) < 6) && (q.size() < DEPTH);
      sa  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      sbe = 4'($urandom_range(1, 15));
      sd  = $urandom & lanes(sbe);
      lv  = 1'($urandom);
      la  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      cyc(sv, sa, sbe, sd, lv, la, ld_be_tab[$urandom_range(0, 6)]);
    end
    idle(DEPTH + 1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
